// File: rtl/retro_sram_pkg.sv
// Shared types and width helpers for the retro SRAM arbiter.
// Holds the sequencer state enum and index/counter width functions.
package retro_sram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } sram_arb_state_t;

    // Width of a requester index; never narrower than one bit.
    function automatic int rr_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must hold 0..ws.
    function automatic int cnt_width(input int ws);
        return (ws > 0) ? $clog2(ws + 1) : 1;
    endfunction

endpackage

// File: rtl/retro_rr_picker.sv
// Combinational round-robin picker: searches from last_i+1 upward.
// Ports: req_i request vector, last_i previous winner, grant_o one-hot, idx_o index.
module retro_rr_picker
    import retro_sram_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = rr_idx_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o
);

    int   p;
    logic hit;

    // Walk N positions starting after last_i; the modulo keeps
    // non-power-of-two port counts wrapping back to port 0.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        hit     = 1'b0;
        p       = 0;
        for (int k = 1; k <= N; k++) begin
            p = (int'(last_i) + k) % N;
            if (!hit && req_i[p[IW-1:0]]) begin
                hit                 = 1'b1;
                grant_o[p[IW-1:0]]  = 1'b1;
                idx_o               = p[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/retro_sram_arbiter.sv
// Round-robin arbiter and access sequencer sharing one async SRAM.
// Ports: per-requester Access/Write/Address/Din in, Dout/Ready/DataReady out;
// Sram* pins to the device, all outputs registered.
module retro_sram_arbiter
    import retro_sram_pkg::*;
#(
    parameter int Requesters      = 4,
    parameter int AddressBusWidth = 16,
    parameter int DataBusWidth    = 8,
    parameter int WaitStates      = 1
) (
    input  logic                                         Clk_i,
    input  logic                                         Reset_n_i,
    input  logic [Requesters-1:0]                        Access_i,
    input  logic [Requesters-1:0]                        Write_i,
    input  logic [Requesters-1:0][AddressBusWidth-1:0]   Address_i,
    input  logic [Requesters-1:0][DataBusWidth-1:0]      Din_i,
    output logic [Requesters-1:0][DataBusWidth-1:0]      Dout_o,
    output logic [Requesters-1:0]                        Ready_o,
    output logic [Requesters-1:0]                        DataReady_o,
    output logic [AddressBusWidth-1:0]                   SramAddress_o,
    output logic                                         SramEnable_o,
    output logic                                         SramWrite_o,
    output logic [DataBusWidth-1:0]                      SramDout_o,
    input  logic [DataBusWidth-1:0]                      SramDin_i
);

    localparam int IW = rr_idx_width(Requesters);
    localparam int CW = cnt_width(WaitStates);

    // Last starts at the top port so port 0 has first priority.
    localparam logic [IW-1:0] LastInit = IW'(Requesters - 1);
    localparam logic [CW-1:0] CntInit  = CW'(WaitStates);
    localparam logic [CW-1:0] CntOne   = CW'(1);

    sram_arb_state_t state_q;

    logic [IW-1:0]   win_q;
    logic [IW-1:0]   last_q;
    logic [CW-1:0]   cnt_q;

    logic [AddressBusWidth-1:0] addr_q;
    logic [DataBusWidth-1:0]    sdo_q;
    logic                       en_q;
    logic                       swr_q;

    logic [Requesters-1:0][DataBusWidth-1:0] dout_q;
    logic [Requesters-1:0]                   ready_q;
    logic [Requesters-1:0]                   drdy_q;

    logic [Requesters-1:0] grant_oh;
    logic [IW-1:0]         grant_idx;

    retro_rr_picker #(
        .N (Requesters)
    ) u_picker (
        .req_i   (Access_i),
        .last_i  (last_q),
        .grant_o (grant_oh),
        .idx_o   (grant_idx)
    );

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            state_q <= IDLE;
            win_q   <= '0;
            last_q  <= LastInit;
            cnt_q   <= '0;
            addr_q  <= '0;
            sdo_q   <= '0;
            en_q    <= 1'b0;
            swr_q   <= 1'b0;
            dout_q  <= '0;
            ready_q <= '1;
            drdy_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|Access_i) begin
                        win_q   <= grant_idx;
                        addr_q  <= Address_i[grant_idx];
                        sdo_q   <= Din_i[grant_idx];
                        swr_q   <= Write_i[grant_idx];
                        en_q    <= 1'b1;
                        cnt_q   <= CntInit;
                        ready_q <= ~grant_oh;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt_q == '0) begin
                        // swr_q still holds the latched direction here.
                        if (!swr_q) begin
                            dout_q[win_q] <= SramDin_i;
                        end
                        en_q          <= 1'b0;
                        swr_q         <= 1'b0;
                        drdy_q[win_q] <= 1'b1;
                        state_q       <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CntOne;
                    end
                end
                DONE: begin
                    // Address and data stay put to give the device hold time.
                    drdy_q  <= '0;
                    ready_q <= '1;
                    last_q  <= win_q;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Dout_o        = dout_q;
    assign Ready_o       = ready_q;
    assign DataReady_o   = drdy_q;
    assign SramAddress_o = addr_q;
    assign SramEnable_o  = en_q;
    assign SramWrite_o   = swr_q;
    assign SramDout_o    = sdo_q;

endmodule

// File: tb/tb_retro_sram_arbiter.sv
// Self-checking bench for retro_sram_arbiter.
// Two instances: 4 ports / 1 wait state and 3 ports / 0 wait states.
module tb_retro_sram_arbiter;

    localparam int WS0 = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int ecount = 0;
    always @(posedge clk) ecount = ecount + 1;

    int errors = 0;
    int checks = 0;

    logic [3:0]        acc0, wr0, rdy0, drdy0;
    logic [3:0][15:0]  addr0;
    logic [3:0][7:0]   din0, dout0;
    logic [15:0]       saddr0;
    logic              sen0, swr0;
    logic [7:0]        sdo0, sdi0;

    logic [2:0]        acc1, wr1, rdy1, drdy1;
    logic [2:0][15:0]  addr1;
    logic [2:0][7:0]   din1, dout1;
    logic [15:0]       saddr1;
    logic              sen1, swr1;
    logic [7:0]        sdo1, sdi1;

    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    logic       pl_en = 1'b0;
    logic [7:0] pl_a  = '0;
    logic [7:0] pl_d  = '0;

    retro_sram_arbiter #(
        .Requesters(4), .AddressBusWidth(16),
        .DataBusWidth(8), .WaitStates(WS0)
    ) u0 (
        .Clk_i(clk), .Reset_n_i(rst_n),
        .Access_i(acc0), .Write_i(wr0),
        .Address_i(addr0), .Din_i(din0),
        .Dout_o(dout0), .Ready_o(rdy0),
        .DataReady_o(drdy0),
        .SramAddress_o(saddr0), .SramEnable_o(sen0),
        .SramWrite_o(swr0), .SramDout_o(sdo0),
        .SramDin_i(sdi0)
    );

    retro_sram_arbiter #(
        .Requesters(3), .AddressBusWidth(16),
        .DataBusWidth(8), .WaitStates(0)
    ) u1 (
        .Clk_i(clk), .Reset_n_i(rst_n),
        .Access_i(acc1), .Write_i(wr1),
        .Address_i(addr1), .Din_i(din1),
        .Dout_o(dout1), .Ready_o(rdy1),
        .DataReady_o(drdy1),
        .SramAddress_o(saddr1), .SramEnable_o(sen1),
        .SramWrite_o(swr1), .SramDout_o(sdo1),
        .SramDin_i(sdi1)
    );

    // Simple async SRAM models, refilled with a known pattern in reset.
    assign sdi0 = mem0[saddr0[7:0]];
    assign sdi1 = mem1[saddr1[7:0]];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) begin
                mem0[i] <= 8'(i * 7 + 3);
                mem1[i] <= 8'(i * 7 + 3);
            end
        end else begin
            if (pl_en)
                mem0[pl_a] <= pl_d;
            else if (sen0 && swr0)
                mem0[saddr0[7:0]] <= sdo0;
            if (sen1 && swr1)
                mem1[saddr1[7:0]] <= sdo1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        acc0 = '0; acc1 = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_reset_u0(input string tag);
        chk({tag, "_rdy0"},   rdy0, 32'hF);
        chk({tag, "_drdy0"},  drdy0, 32'h0);
        chk({tag, "_sen0"},   sen0, 32'h0);
        chk({tag, "_swr0"},   swr0, 32'h0);
        chk({tag, "_saddr0"}, saddr0, 32'h0);
        chk({tag, "_sdo0"},   sdo0, 32'h0);
        chk({tag, "_dout0"},  dout0, 32'h0);
    endtask

    task automatic race0(input logic [3:0] m, output int w, output int lat);
        int n0;
        w = -1; lat = -1;
        @(negedge clk);
        acc0 = m; wr0 = '0;
        n0 = ecount + 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (drdy0 != '0) begin
                for (int p = 0; p < 4; p++) if (drdy0[p]) w = p;
                lat = ecount + 1 - n0;
                break;
            end
        end
        acc0 = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic race1(input logic [2:0] m, output int w, output int lat);
        int n0;
        w = -1; lat = -1;
        @(negedge clk);
        acc1 = m; wr1 = '0;
        n0 = ecount + 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (drdy1 != '0) begin
                for (int p = 0; p < 3; p++) if (drdy1[p]) w = p;
                lat = ecount + 1 - n0;
                break;
            end
        end
        acc1 = '0;
        repeat (3) @(negedge clk);
    endtask

    // Transaction-level reference: one access at a time, each taking
    // WS0+3 cycles, winner chosen by scanning ports after the last one.
    task automatic random_test();
        logic [7:0]  refm [256];
        logic [3:0]  pend, e_dr, e_rdy;
        logic [3:0][7:0] exp_d;
        int c, gN, gw, next_grant, last_m, p;
        bit gwr, act;
        logic [7:0]  gdat;
        logic [15:0] gaddr;
        for (int i = 0; i < 256; i++) refm[i] = 8'(i * 7 + 3);
        pend = '0; exp_d = '0;
        gN = -100; gw = 0; gwr = 1'b0; gdat = '0; gaddr = '0;
        next_grant = 0; last_m = 3;
        for (int it = 0; it < 1500; it++) begin
            @(negedge clk);
            c = ecount + 1;
            act = (c >= gN + 1) && (c <= gN + 1 + WS0);
            e_rdy = '1;
            if (c >= gN + 1 && c <= gN + 2 + WS0) e_rdy[gw] = 1'b0;
            e_dr = '0;
            if (c == gN + 2 + WS0) begin
                e_dr[gw] = 1'b1;
                if (!gwr) exp_d[gw] = gdat;
            end
            chk("rnd_drdy", drdy0, e_dr);
            chk("rnd_rdy",  rdy0, e_rdy);
            chk("rnd_sen",  sen0, act);
            chk("rnd_swr",  swr0, act && gwr);
            chk("rnd_dout", dout0, exp_d);
            if (act) chk("rnd_addr", saddr0, gaddr);
            for (int q = 0; q < 4; q++) begin
                if (e_dr[q]) pend[q] = 1'b0;
                if (!pend[q]) begin
                    wr0[q]   = 1'($urandom);
                    addr0[q] = 16'($urandom);
                    din0[q]  = 8'($urandom);
                    if ($urandom_range(0, 2) == 0) pend[q] = 1'b1;
                end
            end
            acc0 = pend;
            if (c >= next_grant && pend != '0) begin
                for (int k = 1; k <= 4; k++) begin
                    p = (last_m + k) % 4;
                    if (pend[p]) begin
                        gN = c; gw = p; gwr = wr0[p];
                        gaddr = addr0[p];
                        if (gwr) refm[addr0[p][7:0]] = din0[p];
                        else gdat = refm[addr0[p][7:0]];
                        last_m = p;
                        next_grant = c + WS0 + 3;
                        break;
                    end
                end
            end
        end
        acc0 = '0;
        repeat (8) @(negedge clk);
    endtask

    typedef struct {
        int          port;
        bit          wr;
        logic [15:0] addr;
        logic [7:0]  din;
        bit          pre_en;
        logic [7:0]  pre;
        logic [7:0]  exp_dout;
    } vec_t;

    task automatic table_test();
        vec_t tv[6];
        bit acc_c;
        logic [3:0] e;
        tv[0] = '{0, 1'b0, 16'h1234, 8'h00, 1'b1, 8'hA5, 8'hA5};
        tv[1] = '{2, 1'b1, 16'h0010, 8'h5C, 1'b0, 8'h00, 8'h00};
        tv[2] = '{3, 1'b0, 16'h0010, 8'h11, 1'b0, 8'h00, 8'h5C};
        tv[3] = '{1, 1'b1, 16'h00FF, 8'h3C, 1'b0, 8'h00, 8'h00};
        tv[4] = '{1, 1'b0, 16'h00FF, 8'h22, 1'b0, 8'h00, 8'h3C};
        tv[5] = '{0, 1'b1, 16'h0020, 8'h77, 1'b0, 8'h00, 8'hA5};
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            if (tv[v].pre_en) begin
                pl_en = 1'b1; pl_a = tv[v].addr[7:0]; pl_d = tv[v].pre;
                @(negedge clk);
                pl_en = 1'b0;
            end
            acc0 = '0;
            acc0[tv[v].port]  = 1'b1;
            wr0[tv[v].port]   = tv[v].wr;
            addr0[tv[v].port] = tv[v].addr;
            din0[tv[v].port]  = tv[v].din;
            for (int k = 1; k <= WS0 + 3; k++) begin
                @(negedge clk);
                acc_c = (k <= WS0 + 1);
                e = '0;
                if (k == WS0 + 2) e[tv[v].port] = 1'b1;
                chk($sformatf("tv%0d_k%0d_sen", v, k), sen0, acc_c);
                chk($sformatf("tv%0d_k%0d_swr", v, k), swr0,
                    acc_c && tv[v].wr);
                chk($sformatf("tv%0d_k%0d_drdy", v, k), drdy0, e);
                chk($sformatf("tv%0d_k%0d_rdy", v, k), rdy0[tv[v].port],
                    k > WS0 + 2);
                if (k <= WS0 + 2) begin
                    chk($sformatf("tv%0d_k%0d_addr", v, k), saddr0,
                        tv[v].addr);
                    if (tv[v].wr)
                        chk($sformatf("tv%0d_k%0d_sdo", v, k), sdo0,
                            tv[v].din);
                end
                if (k == WS0 + 2) acc0 = '0;
            end
            chk($sformatf("tv%0d_dout", v), dout0[tv[v].port],
                tv[v].exp_dout);
        end
    endtask

    task automatic rr_test();
        int n, prevc, p;
        n = 0; prevc = 0;
        @(negedge clk);
        acc0 = 4'hF; wr0 = '0;
        for (int i = 0; i < 40 && n < 6; i++) begin
            @(negedge clk);
            if (drdy0 != '0) begin
                p = -1;
                for (int q = 0; q < 4; q++) if (drdy0[q]) p = q;
                chk($sformatf("rr_order%0d", n), p, n % 4);
                if (n > 0)
                    chk($sformatf("rr_gap%0d", n), ecount + 1 - prevc, 4);
                prevc = ecount + 1;
                n++;
            end
        end
        acc0 = '0;
        chk("rr_pulses", n, 6);
        repeat (6) @(negedge clk);
    endtask

    task automatic reset_mid_write_test();
        int w, lat;
        bit seen;
        @(negedge clk);
        acc0 = 4'b0010; wr0 = 4'b0010;
        addr0[1] = 16'h0040; din0[1] = 8'h99;
        @(negedge clk);
        chk("rmw_swr_before", swr0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rmw_swr_async", swr0, 1'b0);
        chk("rmw_sen_async", sen0, 1'b0);
        acc0 = '0; wr0 = '0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_u0("rmw_after");
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (drdy0 != '0) seen = 1'b1;
        end
        chk("rmw_no_drdy", seen, 1'b0);
        race0(4'b0011, w, lat);
        chk("rmw_first_win", w, 0);
        chk("rmw_latency", lat, WS0 + 2);
    endtask

    task automatic u1_tests();
        int w, lat;
        @(negedge clk);
        acc1 = 3'b001; wr1 = '0; addr1[0] = 16'h0005;
        @(negedge clk);
        chk("ws0_sen_n1", sen1, 1'b1);
        chk("ws0_drdy_n1", drdy1, 3'b000);
        chk("ws0_rdy_n1", rdy1, 3'b110);
        @(negedge clk);
        chk("ws0_sen_n2", sen1, 1'b0);
        chk("ws0_drdy_n2", drdy1, 3'b001);
        chk("ws0_dout_n2", dout1[0], 8'h26);
        acc1 = '0;
        repeat (3) @(negedge clk);
        race1(3'b100, w, lat);
        chk("wrap_setup_a", w, 2);
        chk("wrap_lat_a", lat, 2);
        race1(3'b110, w, lat);
        chk("wrap_to_1", w, 1);
        race1(3'b100, w, lat);
        chk("wrap_setup_b", w, 2);
        race1(3'b111, w, lat);
        chk("wrap_to_0", w, 0);
        chk("wrap_lat_b", lat, 2);
    endtask

    initial begin
        acc0 = '0; wr0 = '0; addr0 = '0; din0 = '0;
        acc1 = '0; wr1 = '0; addr1 = '0; din1 = '0;
        @(negedge clk);
        @(negedge clk);
        check_reset_u0("rst");
        chk("rst_rdy1", rdy1, 32'h7);
        chk("rst_sen1", sen1, 32'h0);
        chk("rst_dout1", dout1, 32'h0);
        rst_n = 1'b1;
        random_test();
        do_reset();
        table_test();
        do_reset();
        rr_test();
        reset_mid_write_test();
        do_reset();
        u1_tests();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
